// File: rtl/fetch_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_redirect_ctrl
//   Owns the fetch PC and drives instruction fetch over a req/gnt/rvalid port.
//   Branch (EX) and trap redirects are applied in the cycle they are seen.
//   Every granted fetch is tagged with its PC in a small FIFO. Responses that
//   belong to a path abandoned by a flush are counted in `discard_r` and dropped.
//
// Ports
//   clk_i, rst_ni                clock, async active-low reset
//   if_stall_i                   front end full, blocks new requests only
//   ex_valid_i, br_taken_i,
//   br_target_i                  EX-stage branch redirect
//   trap_req_i, trap_vec_i       trap redirect (wins over a branch)
//   fetch_req_o, fetch_addr_o    request side of the imem port
//   fetch_gnt_i                  request accepted this cycle
//   fetch_rvalid_i,
//   fetch_rdata_i                in-order responses, one per grant
//   instr_valid_o, instr_o,
//   instr_pc_o                   instruction delivered to IF/ID (same cycle as rvalid)
//   flush_o                      kill IF/ID contents
//   misalign_o, misalign_addr_o  registered report of a misaligned branch target
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              MAX_OUTST = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            if_stall_i,
    input  logic            br_taken_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            trap_req_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            fetch_req_o,
    output logic [XLEN-1:0] fetch_addr_o,
    input  logic            fetch_gnt_i,
    input  logic            fetch_rvalid_i,
    input  logic [31:0]     fetch_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    output logic            flush_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // The tag FIFO always has four slots so the 2-bit pointers wrap naturally;
    // MAX_OUTST (1..4) bounds how many are ever in use.
    localparam logic [2:0] MAX_O = 3'(MAX_OUTST);

    state_e          state_r, state_nxt_s;
    logic [XLEN-1:0] pc_r, pc_nxt_s;
    logic [2:0]      outst_r, outst_nxt_s;
    logic [2:0]      discard_r, discard_nxt_s;
    logic [XLEN-1:0] fifo_r [4];
    logic [1:0]      wr_ptr_r, rd_ptr_r;
    logic            misalign_r;
    logic [XLEN-1:0] misalign_addr_r;

    logic br_valid_s, tgt_ok_s, redir_s, misal_s, flush_s;
    logic rsp_s, req_s, gnt_s;

    // A branch seen while halted is ignored: only a trap may leave HALT.
    assign br_valid_s = ex_valid_i & br_taken_i & (state_r != ST_HALT);
    assign tgt_ok_s   = (br_target_i[1:0] == 2'b00);
    assign redir_s    = trap_req_i | (br_valid_s & tgt_ok_s);
    assign misal_s    = br_valid_s & ~tgt_ok_s & ~trap_req_i;
    assign flush_s    = redir_s | misal_s;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_s      = fetch_rvalid_i & (outst_r != 3'd0);
    assign req_s      = (state_r == ST_RUN) & ~if_stall_i & (outst_r < MAX_O) & ~flush_s;
    assign gnt_s      = req_s & fetch_gnt_i;

    assign fetch_req_o     = req_s;
    assign fetch_addr_o    = pc_r;
    assign flush_o         = flush_s;
    assign instr_valid_o   = rsp_s & (discard_r == 3'd0) & ~flush_s;
    assign instr_o         = fetch_rdata_i;
    assign instr_pc_o      = fifo_r[rd_ptr_r];
    assign misalign_o      = misalign_r;
    assign misalign_addr_o = misalign_addr_r;

    // Next PC, outstanding/discard counters and FSM state.
    always_comb begin
        pc_nxt_s      = pc_r;
        outst_nxt_s   = outst_r + {2'b00, gnt_s} - {2'b00, rsp_s};
        discard_nxt_s = discard_r;
        state_nxt_s   = state_r;

        if (redir_s) begin
            pc_nxt_s = trap_req_i ? trap_vec_i : br_target_i;
        end else if (gnt_s) begin
            pc_nxt_s = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
        end else begin
            pc_nxt_s = pc_r;
        end

        // Everything still outstanding after a flush belongs to the abandoned
        // path; this includes the misaligned-branch case, whose fall-through
        // fetches must not reach IF/ID either.
        if (flush_s) begin
            discard_nxt_s = outst_nxt_s;
        end else if (rsp_s && (discard_r != 3'd0)) begin
            discard_nxt_s = discard_r - 3'd1;
        end else begin
            discard_nxt_s = discard_r;
        end

        case (state_r)
            ST_BOOT: begin
                if (misal_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (misal_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (trap_req_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State, PC, counters and the PC tag FIFO.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_PC;
            outst_r   <= 3'd0;
            discard_r <= 3'd0;
            wr_ptr_r  <= 2'd0;
            rd_ptr_r  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_r[i] <= {XLEN{1'b0}};
            end
        end else begin
            state_r   <= state_nxt_s;
            pc_r      <= pc_nxt_s;
            outst_r   <= outst_nxt_s;
            discard_r <= discard_nxt_s;
            if (gnt_s) begin
                fifo_r[wr_ptr_r] <= pc_r;
                wr_ptr_r         <= wr_ptr_r + 2'd1;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rsp_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // One-cycle misaligned-target report.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            misalign_r      <= 1'b0;
            misalign_addr_r <= {XLEN{1'b0}};
        end else begin
            misalign_r <= misal_s;
            if (misal_s) begin
                misalign_addr_r <= br_target_i;
            end else begin
                misalign_addr_r <= misalign_addr_r;
            end
        end
    end

    fetch_redirect_ctrl_chk #(.MAX_OUTST(MAX_OUTST)) u_chk (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .rvalid (fetch_rvalid_i),
        .outst  (outst_r)
    );

endmodule

// -----------------------------------------------------------------------------
// fetch_redirect_ctrl_chk
//   Protocol checks for the imem port: no response without an outstanding
//   fetch, and the outstanding count never exceeds MAX_OUTST.
//   Ports: clk, rst_n, rvalid (response valid), outst (outstanding count).
// -----------------------------------------------------------------------------
module fetch_redirect_ctrl_chk #(
    parameter int MAX_OUTST = 2
) (
    input logic       clk,
    input logic       rst_n,
    input logic       rvalid,
    input logic [2:0] outst
);

    a_rvalid_needs_outst: assert property (@(posedge clk) disable iff (!rst_n)
        rvalid |-> (outst != 3'd0));

    a_outst_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outst <= 3'(MAX_OUTST));

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
module tb_fetch_redirect_ctrl;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        stall, br_taken, ex_valid, trap_req, gnt, rvalid;
    logic [31:0] br_target, trap_vec, rdata;
    logic        req, ivalid, flush, mis;
    logic [31:0] addr, instr, ipc, mis_addr;

    logic        w_gnt;
    logic        w_req, w_ivalid, w_flush, w_mis;
    logic [31:0] w_addr, w_instr, w_ipc, w_mis_addr;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=boot 1=run 2=halt; queue of outstanding fetch PCs
    // each flagged "wrong path" once a flush has been seen after its grant.
    int          m_state;
    logic [31:0] m_pc;
    logic [31:0] q_pc[$];
    bit          q_wrong[$];
    bit          m_mis;
    logic [31:0] m_mis_addr;

    fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000), .MAX_OUTST(MAXO)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .if_stall_i(stall), .br_taken_i(br_taken),
        .ex_valid_i(ex_valid), .br_target_i(br_target), .trap_req_i(trap_req),
        .trap_vec_i(trap_vec), .fetch_req_o(req), .fetch_addr_o(addr),
        .fetch_gnt_i(gnt), .fetch_rvalid_i(rvalid), .fetch_rdata_i(rdata),
        .instr_valid_o(ivalid), .instr_o(instr), .instr_pc_o(ipc), .flush_o(flush),
        .misalign_o(mis), .misalign_addr_o(mis_addr)
    );

    fetch_redirect_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .MAX_OUTST(MAXO)) u_dut_w (
        .clk_i(clk), .rst_ni(rst_n), .if_stall_i(1'b0), .br_taken_i(1'b0),
        .ex_valid_i(1'b0), .br_target_i(32'h0), .trap_req_i(1'b0),
        .trap_vec_i(32'h0), .fetch_req_o(w_req), .fetch_addr_o(w_addr),
        .fetch_gnt_i(w_gnt), .fetch_rvalid_i(1'b0), .fetch_rdata_i(32'h0),
        .instr_valid_o(w_ivalid), .instr_o(w_instr), .instr_pc_o(w_ipc), .flush_o(w_flush),
        .misalign_o(w_mis), .misalign_addr_o(w_mis_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc = 32'h0;
        q_pc.delete();
        q_wrong.delete();
        m_mis = 1'b0;
        m_mis_addr = 32'h0;
    endtask

    task automatic clear_redirects();
        ex_valid = 1'b0; br_taken = 1'b0; trap_req = 1'b0;
        br_target = 32'h0; trap_vec = 32'h0;
    endtask

    function automatic bit can_rsp();
        return q_pc.size() > 0;
    endfunction

    // Compare DUT outputs against the model for the current inputs, advance the
    // model by one clock, then wait for the next driving point (negedge).
    task automatic step();
        bit br, ok, redir, misal, fl, resp, e_req, e_valid;
        #1;
        br    = ex_valid && br_taken && (m_state != 2);
        ok    = (br_target[1:0] == 2'b00);
        redir = trap_req || (br && ok);
        misal = br && !ok && !trap_req;
        fl    = redir || misal;
        resp  = rvalid && (q_pc.size() > 0);
        e_req = (m_state == 1) && !stall && (q_pc.size() < MAXO) && !fl;
        e_valid = resp && !q_wrong[0] && !fl;

        chk("fetch_req", {31'b0, req}, {31'b0, e_req});
        chk("fetch_addr", addr, m_pc);
        chk("flush", {31'b0, flush}, {31'b0, fl});
        chk("instr_valid", {31'b0, ivalid}, {31'b0, e_valid});
        if (e_valid) begin
            chk("instr_pc", ipc, q_pc[0]);
            chk("instr", instr, rdata);
        end
        chk("misalign", {31'b0, mis}, {31'b0, m_mis});
        if (m_mis) chk("misalign_addr", mis_addr, m_mis_addr);

        if (resp) begin
            void'(q_pc.pop_front());
            void'(q_wrong.pop_front());
        end
        if (e_req && gnt) begin
            q_pc.push_back(m_pc);
            q_wrong.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
        if (fl) foreach (q_wrong[i]) q_wrong[i] = 1'b1;
        if (redir) m_pc = trap_req ? trap_vec : br_target;
        if (misal) m_state = 2;
        else if (m_state == 2 && trap_req) m_state = 1;
        else if (m_state == 0) m_state = 1;
        m_mis = misal;
        if (misal) m_mis_addr = br_target;
        @(negedge clk);
    endtask

    task automatic random_cycle();
        logic [31:0] t;
        stall = ($urandom_range(0, 3) == 0);
        gnt = 1'($urandom_range(0, 1));
        rvalid = can_rsp() && ($urandom_range(0, 9) < 6);
        rdata = $urandom;
        if (m_state == 2) begin
            ex_valid = 1'b0; br_taken = 1'b0;
            trap_req = ($urandom_range(0, 5) == 0);
        end else begin
            ex_valid = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 4) == 0);
            trap_req = ($urandom_range(0, 29) == 0);
        end
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        br_target = t;
        t = $urandom;
        t[1:0] = 2'b00;
        trap_vec = t;
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, req}, 32'h0);
        chk({tag, "_addr"}, addr, 32'h0);
        chk({tag, "_ivalid"}, {31'b0, ivalid}, 32'h0);
        chk({tag, "_flush"}, {31'b0, flush}, 32'h0);
        chk({tag, "_mis"}, {31'b0, mis}, 32'h0);
        chk({tag, "_mis_addr"}, mis_addr, 32'h0);
        chk({tag, "_w_addr"}, w_addr, 32'hFFFF_FFFC);
        chk({tag, "_w_req"}, {31'b0, w_req}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0; w_gnt = 1'b0;
        clear_redirects();
        model_reset();
        @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // BOOT cycle: no request
        gnt = 1'b1; w_gnt = 1'b1; rvalid = 1'b0;
        #1 chk("boot_no_req", {31'b0, req}, 32'h0);
        step();
        // sequential fetch 0,4,8 with rvalid one cycle after grant
        rvalid = can_rsp(); rdata = 32'h1111_0000;
        #1 chk("seq_addr0", addr, 32'h0);
        chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        chk("wrap_req0", {31'b0, w_req}, 32'h1);
        step();
        rvalid = can_rsp(); rdata = 32'h1111_0004;
        #1 chk("seq_addr4", addr, 32'h4);
        chk("seq_pc0", ipc, 32'h0);
        chk("seq_valid0", {31'b0, ivalid}, 32'h1);
        chk("wrap_addr1", w_addr, 32'h0);
        step();
        rvalid = can_rsp(); rdata = 32'h1111_0008;
        #1 chk("seq_addr8", addr, 32'h8);
        chk("seq_pc4", ipc, 32'h4);
        chk("wrap_req_full", {31'b0, w_req}, 32'h0);
        step();
        // build outst=2, then branch to 0x100
        rvalid = 1'b0;
        step();
        ex_valid = 1'b1; br_taken = 1'b1; br_target = 32'h100;
        #1 chk("br_flush", {31'b0, flush}, 32'h1);
        chk("br_req_off", {31'b0, req}, 32'h0);
        step();
        clear_redirects();
        rvalid = can_rsp();
        #1 chk("br_drop1", {31'b0, ivalid}, 32'h0);
        step();
        rvalid = can_rsp();
        #1 chk("br_drop2", {31'b0, ivalid}, 32'h0);
        chk("br_new_addr", addr, 32'h100);
        step();
        rvalid = can_rsp(); rdata = 32'hABCD_0100;
        #1 chk("br_deliver", {31'b0, ivalid}, 32'h1);
        chk("br_deliver_pc", ipc, 32'h100);
        step();
        // trap and branch together: trap wins
        rvalid = can_rsp();
        trap_req = 1'b1; trap_vec = 32'h80; ex_valid = 1'b1; br_taken = 1'b1; br_target = 32'h200;
        step();
        clear_redirects();
        rvalid = can_rsp();
        #1 chk("trap_prio_addr", addr, 32'h80);
        step();
        // misaligned target 0x102
        rvalid = can_rsp();
        ex_valid = 1'b1; br_taken = 1'b1; br_target = 32'h102;
        #1 chk("mis_flush", {31'b0, flush}, 32'h1);
        step();
        clear_redirects();
        rvalid = can_rsp();
        #1 chk("mis_pulse", {31'b0, mis}, 32'h1);
        chk("mis_addr", mis_addr, 32'h102);
        chk("halt_no_req", {31'b0, req}, 32'h0);
        step();
        for (int i = 0; i < 3; i++) begin
            rvalid = can_rsp();
            #1 chk("halt_idle_req", {31'b0, req}, 32'h0);
            step();
        end
        trap_req = 1'b1; trap_vec = 32'h80;
        step();
        clear_redirects();
        rvalid = can_rsp();
        #1 chk("halt_exit_addr", addr, 32'h80);
        chk("halt_exit_req", {31'b0, req}, 32'h1);
        step();
        // grant withheld for 5 cycles while stall toggles
        for (int i = 0; i < 5; i++) begin
            gnt = 1'b0; stall = i[0];
            rvalid = can_rsp() && (i > 2);
            step();
        end
        stall = 1'b0; gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rvalid = can_rsp();
            step();
        end

        for (int i = 0; i < 3000; i++) random_cycle();

        // reset while fetches are in flight
        clear_redirects();
        stall = 1'b0; rvalid = 1'b0; gnt = 1'b0;
        rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) random_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
